fade_sequencer: RTL

Day/night fade controller. Sequences an 8-bit brightness level through a programmable rise / hold-high / fall / hold-low cycle, with a programmable step rate, level bounds and dwell time. Supports one-shot or continuous operation, pause and abort. Its fade_level output feeds the LED/PWM datapath.

---
 rtl/fade_sequencer_if.sv | 46 ++++
 rtl/fade_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fade_sequencer_if.sv
// Bus bundle for the day/night fade sequencer.
// The master drives the controls and the slave (the sequencer) drives the status.
// The optional cycle_count status signal is present only when
// FADE_SEQ_CYCLE_CNT_EN is defined.
interface fade_sequencer_if #(
  parameter int LEVEL_W = 8,
  parameter int DIV_W   = 20,
  parameter int HOLD_W  = 8
);
  logic               enable;
  logic               start;
  logic               stop;
  logic               mode;
  logic [DIV_W-1:0]   step_div;
  logic [HOLD_W-1:0]  hold_steps;
  logic [LEVEL_W-1:0] lvl_min;
  logic [LEVEL_W-1:0] lvl_max;
  logic [LEVEL_W-1:0] fade_level;
  logic               direction;
  logic [2:0]         state;
  logic               busy;
  logic               cycle_done;
`ifdef FADE_SEQ_CYCLE_CNT_EN
  logic [15:0]        cycle_count;

  modport master (
    output enable, start, stop, mode, step_div, hold_steps, lvl_min, lvl_max,
    input  fade_level, direction, state, busy, cycle_done, cycle_count
  );

  modport slave (
    input  enable, start, stop, mode, step_div, hold_steps, lvl_min, lvl_max,
    output fade_level, direction, state, busy, cycle_done, cycle_count
  );
`else
  modport master (
    output enable, start, stop, mode, step_div, hold_steps, lvl_min, lvl_max,
    input  fade_level, direction, state, busy, cycle_done
  );

  modport slave (
    input  enable, start, stop, mode, step_div, hold_steps, lvl_min, lvl_max,
    output fade_level, direction, state, busy, cycle_done
  );
`endif
endinterface

// File: rtl/fade_sequencer.sv
// Day/night fade sequencer: walks an 8-bit brightness through
// rise / hold-high / fall / hold-low at a programmable step rate.
// Optional feature macro: FADE_SEQ_CYCLE_CNT_EN adds a 16-bit cycle_count
// status output that counts completed cycles since the last accepted start.
module fade_sequencer #(
  parameter int LEVEL_W = 8,
  parameter int DIV_W   = 20,
  parameter int HOLD_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  fade_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               direction_q, direction_d;
  logic [DIV_W-1:0]   prescale_q, prescale_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic               cycleDone_q, cycleDone_d;
  logic               mode_q, mode_d;
`ifdef FADE_SEQ_CYCLE_CNT_EN
  logic [15:0]        cycleCount_q, cycleCount_d;
`endif

  logic active;
  logic tick;
  logic startOk;

  // The prescaler only runs while sequencing and not paused; >= keeps a shrinking step_div safe.
  assign active  = bus.enable && (state_q != IDLE);
  assign tick    = active && (prescale_q >= bus.step_div);
  assign startOk = !bus.stop && bus.start && (state_q == IDLE) && (bus.lvl_min <= bus.lvl_max);

  // State register: every piece of sequencer state, async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= '0;
      direction_q  <= 1'b0;
      prescale_q   <= '0;
      holdCnt_q    <= '0;
      cycleDone_q  <= 1'b0;
      mode_q       <= 1'b0;
`ifdef FADE_SEQ_CYCLE_CNT_EN
      cycleCount_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      direction_q  <= direction_d;
      prescale_q   <= prescale_d;
      holdCnt_q    <= holdCnt_d;
      cycleDone_q  <= cycleDone_d;
      mode_q       <= mode_d;
`ifdef FADE_SEQ_CYCLE_CNT_EN
      cycleCount_q <= cycleCount_d;
`endif
    end
  end

  // Next-state logic with priority stop > start > tick; a paused cycle leaves everything frozen.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    direction_d = direction_q;
    prescale_d  = prescale_q;
    holdCnt_d   = holdCnt_q;
    mode_d      = mode_q;
    cycleDone_d = 1'b0;

    if (bus.stop) begin
      state_d    = IDLE;
      prescale_d = '0;
      holdCnt_d  = '0;
    end else if (startOk) begin
      state_d     = RISE;
      level_d     = bus.lvl_min;
      direction_d = 1'b0;
      prescale_d  = '0;
      mode_d      = bus.mode;
    end else if (active) begin
      prescale_d = tick ? '0 : prescale_q + DIV_W'(1);
      if (tick) begin
        case (state_q)
          RISE: begin
            if (level_q < bus.lvl_max) begin
              level_d = level_q + LEVEL_W'(1);
            end else begin
              level_d     = bus.lvl_max;
              state_d     = HOLD_HI;
              direction_d = 1'b1;
              holdCnt_d   = '0;
            end
          end
          HOLD_HI: begin
            if (holdCnt_q == bus.hold_steps) begin
              state_d = FALL;
            end else begin
              holdCnt_d = holdCnt_q + HOLD_W'(1);
            end
          end
          FALL: begin
            if (level_q > bus.lvl_min) begin
              level_d = level_q - LEVEL_W'(1);
            end else begin
              level_d     = bus.lvl_min;
              state_d     = HOLD_LO;
              direction_d = 1'b0;
              holdCnt_d   = '0;
            end
          end
          HOLD_LO: begin
            if (holdCnt_q == bus.hold_steps) begin
              cycleDone_d = 1'b1;
              state_d     = mode_q ? IDLE : RISE;
            end else begin
              holdCnt_d = holdCnt_q + HOLD_W'(1);
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

`ifdef FADE_SEQ_CYCLE_CNT_EN
  // Completed-cycle counter: restarts on an accepted start and wraps naturally.
  always_comb begin
    cycleCount_d = cycleCount_q;
    if (startOk) begin
      cycleCount_d = '0;
    end else if (cycleDone_d) begin
      cycleCount_d = cycleCount_q + 16'd1;
    end
  end
`endif

  // Output logic: registered status straight out, busy decoded from the state.
  always_comb begin
    bus.fade_level  = level_q;
    bus.direction   = direction_q;
    bus.state       = state_q;
    bus.busy        = (state_q != IDLE);
    bus.cycle_done  = cycleDone_q;
`ifdef FADE_SEQ_CYCLE_CNT_EN
    bus.cycle_count = cycleCount_q;
`endif
  end

endmodule
